// File: rtl/iob_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// iob_plic_claim_ctrl
//   Claims an interrupt from a PLIC target over an IOb manager port, hands the
//   claimed ID to a handler, waits for the handler to finish, then writes the
//   ID back to the claim/complete register.
//
//   Optional feature: define IOB_PLIC_CLAIM_CTRL_TIMEOUT_EN to add a service
//   timeout. After TIMEOUT SERVICE cycles without done_i, timeout_o pulses and
//   the ID is completed automatically. Without the macro, timeout_o is tied to
//   0 and SERVICE waits indefinitely.
//
// Ports
//   clk_i, arst_i                 clock, asynchronous active-high reset
//   en_i                          allows a new claim to start from IDLE
//   irq_i                         PLIC interrupt request for this target
//   iob_avalid_o/addr/wdata/wstrb IOb manager request (read when wstrb == 0)
//   iob_ready_i/rvalid_i/rdata_i  IOb manager response
//   id_o, id_valid_o, id_ready_i  claimed-ID handoff to the handler
//   done_i                        handler finished servicing id_o
//   spurious_o                    one-cycle pulse when a claim returns ID 0
//   served_cnt_o                  completed-interrupt count (wraps)
//   busy_o                        sequencer not IDLE
//   timeout_o                     one-cycle pulse on service timeout
// -----------------------------------------------------------------------------
module iob_plic_claim_ctrl #(
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 32,
  parameter int          ID_W       = 6,
  parameter int unsigned CLAIM_ADDR = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic              irq_i,
  output logic              iob_avalid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i,
  output logic [ID_W-1:0]   id_o,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  input  logic              done_i,
  output logic              spurious_o,
  output logic [15:0]       served_cnt_o,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_REQ,
    CLAIM_WAIT,
    PRESENT,
    SERVICE,
    COMPLETE
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [15:0]     served_cnt_q;
  logic            spurious_q;
  logic            rsp_zero;
  logic            tmo_hit;
  logic            rdata_unused;

  assign rsp_zero     = (iob_rdata_i[ID_W-1:0] == '0);
  // Only the low ID_W bits of the claim response carry the ID.
  assign rdata_unused = ^iob_rdata_i;

`ifdef IOB_PLIC_CLAIM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  // Held at zero outside SERVICE, so it is clear on every SERVICE entry.
  assign tmo_hit = (state_q == SERVICE) && !done_i &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (state_q != SERVICE) tmo_cnt_q <= '0;
      else                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;

  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      id_q         <= '0;
      served_cnt_q <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      spurious_q <= (state_q == CLAIM_WAIT) && iob_rvalid_i && rsp_zero;
      // rvalid is only looked at in CLAIM_WAIT, which ignores any response
      // coinciding with the accepted request cycle.
      if ((state_q == CLAIM_WAIT) && iob_rvalid_i)
        id_q <= iob_rdata_i[ID_W-1:0];
      if ((state_q == COMPLETE) && iob_ready_i)
        served_cnt_q <= served_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (irq_i && en_i)      state_d = CLAIM_REQ;
      CLAIM_REQ:  if (iob_ready_i)        state_d = CLAIM_WAIT;
      CLAIM_WAIT: if (iob_rvalid_i)       state_d = rsp_zero ? IDLE : PRESENT;
      PRESENT:    if (id_ready_i)         state_d = SERVICE;
      SERVICE:    if (done_i || tmo_hit)  state_d = COMPLETE;
      COMPLETE:   if (iob_ready_i)        state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    case (state_q)
      CLAIM_REQ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(CLAIM_ADDR);
      end
      COMPLETE: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(CLAIM_ADDR);
        iob_wdata_o  = DATA_W'(id_q);
        iob_wstrb_o  = '1;
      end
      default: ;
    endcase
  end

  assign id_o         = id_q;
  assign id_valid_o   = (state_q == PRESENT);
  assign busy_o       = (state_q != IDLE);
  assign spurious_o   = spurious_q;
  assign served_cnt_o = served_cnt_q;

endmodule

// File: tb/tb_iob_plic_claim_ctrl.sv
`timescale 1ns/1ps
module tb_iob_plic_claim_ctrl;

  localparam int          ADDR_W     = 16;
  localparam int          DATA_W     = 32;
  localparam int          ID_W       = 6;
  localparam int unsigned CLAIM_ADDR = 'h2004;
  localparam int unsigned TIMEOUT    = 8;

  localparam int M_NORMAL = 0;
  localparam int M_RESET  = 1;
  localparam int M_NODONE = 2;

  logic                clk_i = 1'b0;
  logic                arst_i;
  logic                en_i;
  logic                irq_i;
  logic                iob_avalid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i;
  logic                iob_rvalid_i;
  logic [DATA_W-1:0]   iob_rdata_i;
  logic [ID_W-1:0]     id_o;
  logic                id_valid_o;
  logic                id_ready_i;
  logic                done_i;
  logic                spurious_o;
  logic [15:0]         served_cnt_o;
  logic                busy_o;
  logic                timeout_o;

  always #5 clk_i = ~clk_i;

  iob_plic_claim_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .CLAIM_ADDR(CLAIM_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .en_i        (en_i),
    .irq_i       (irq_i),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_ready_i (iob_ready_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i (iob_rdata_i),
    .id_o        (id_o),
    .id_valid_o  (id_valid_o),
    .id_ready_i  (id_ready_i),
    .done_i      (done_i),
    .spurious_o  (spurious_o),
    .served_cnt_o(served_cnt_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: what the bus and handler should have seen so far.
  int unsigned m_served = 0;
  int          m_spur   = 0;
  int          m_tmo    = 0;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
  } wr_t;

  wr_t wr_q[$];
  int  n_rd_acc = 0;
  int  n_spur   = 0;
  int  n_tmo    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Bus observer: values seen mid-cycle are the ones the next edge samples.
  always @(negedge clk_i) begin
    if (iob_avalid_o === 1'b1 && iob_ready_i === 1'b1) begin
      if (iob_wstrb_o == '0) n_rd_acc++;
      else wr_q.push_back({iob_addr_o, iob_wdata_o, iob_wstrb_o});
    end
    if (iob_avalid_o === 1'b0)
      chk("idle_bus_zero", {iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
    if (spurious_o === 1'b1) n_spur++;
    if (timeout_o === 1'b1) n_tmo++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One full claim/complete transaction with the given handshake delays.
  task automatic run_claim(input logic [ID_W-1:0] id, input int rq_w, input int rv_w,
                           input int pr_w, input int sv_w, input int cp_w, input int mode);
    logic [DATA_W-1:0] rd;
    int rd0;
    wr_t w;
    rd0 = n_rd_acc;
    irq_i = 1'b1;
    en_i  = 1'b1;
    tick();
    chk("req_avalid", iob_avalid_o, 1);
    chk("req_addr", iob_addr_o, CLAIM_ADDR);
    chk("req_wdata", iob_wdata_o, 0);
    chk("req_wstrb", iob_wstrb_o, 0);
    chk("req_busy", busy_o, 1);
    irq_i = 1'b0;
    en_i  = 1'($urandom_range(0, 1));
    for (int i = 0; i < rq_w; i++) begin
      tick();
      chk("req_hold_avalid", iob_avalid_o, 1);
      chk("req_hold_addr", iob_addr_o, CLAIM_ADDR);
    end
    iob_ready_i  = 1'b1;
    iob_rvalid_i = 1'b1;
    iob_rdata_i  = $urandom();
    tick();
    iob_ready_i  = 1'b0;
    iob_rvalid_i = 1'b0;
    chk("req_accepted", n_rd_acc - rd0, 1);
    chk("wait_avalid", iob_avalid_o, 0);
    chk("wait_idvalid", id_valid_o, 0);
    chk("wait_busy", busy_o, 1);
    for (int i = 0; i < rv_w; i++) begin
      tick();
      chk("wait_hold_avalid", iob_avalid_o, 0);
      chk("wait_hold_busy", busy_o, 1);
    end
    rd = $urandom();
    rd[ID_W-1:0] = id;
    iob_rvalid_i = 1'b1;
    iob_rdata_i  = rd;
    tick();
    iob_rvalid_i = 1'b0;
    iob_rdata_i  = $urandom();
    if (id == '0) begin
      m_spur++;
      chk("spur_pulse", spurious_o, 1);
      chk("spur_busy", busy_o, 0);
      chk("spur_idvalid", id_valid_o, 0);
      tick();
      chk("spur_one_cycle", spurious_o, 0);
      chk("spur_count", n_spur, m_spur);
      chk("spur_no_write", wr_q.size(), 0);
      chk("spur_served", served_cnt_o, m_served);
      return;
    end
    chk("present_valid", id_valid_o, 1);
    chk("present_id", id_o, id);
    done_i = 1'b1;  // must be ignored before SERVICE
    for (int i = 0; i < pr_w; i++) begin
      tick();
      chk("present_hold_valid", id_valid_o, 1);
      chk("present_hold_id", id_o, id);
    end
    done_i     = 1'b0;
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    chk("svc_idvalid", id_valid_o, 0);
    chk("svc_busy", busy_o, 1);
    chk("svc_avalid", iob_avalid_o, 0);
    if (mode == M_RESET) begin
      #2 arst_i = 1'b1;
      #1;
      chk("rst_bus_zero", {iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
      chk("rst_out_zero", {id_o, id_valid_o, spurious_o, served_cnt_o, busy_o, timeout_o}, 0);
      m_served = 0;
      tick();
      arst_i = 1'b0;
      done_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("rst_stays_idle", busy_o, 0);
      end
      done_i = 1'b0;
      chk("rst_no_write", wr_q.size(), 0);
      return;
    end
    if (mode == M_NODONE) begin
`ifdef IOB_PLIC_CLAIM_CTRL_TIMEOUT_EN
      for (int i = 1; i < int'(TIMEOUT); i++) begin
        tick();
        chk("tmo_early", timeout_o, 0);
        chk("tmo_early_avalid", iob_avalid_o, 0);
      end
      tick();
      chk("tmo_pulse", timeout_o, 1);
      m_tmo++;
`else
      for (int i = 0; i < 100; i++) begin
        tick();
        chk("nodone_avalid", iob_avalid_o, 0);
        chk("nodone_busy", busy_o, 1);
      end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
`endif
    end else begin
      for (int i = 0; i < sv_w; i++) begin
        tick();
        chk("svc_hold_avalid", iob_avalid_o, 0);
      end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("cpl_no_tmo", timeout_o, 0);
    end
    chk("cpl_avalid", iob_avalid_o, 1);
    chk("cpl_addr", iob_addr_o, CLAIM_ADDR);
    chk("cpl_wdata", iob_wdata_o, id);
    chk("cpl_wstrb", iob_wstrb_o, 'hF);
    for (int i = 0; i < cp_w; i++) begin
      tick();
      chk("cpl_hold_avalid", iob_avalid_o, 1);
      chk("cpl_hold_wdata", iob_wdata_o, id);
    end
    iob_ready_i = 1'b1;
    tick();
    iob_ready_i = 1'b0;
    m_served = (m_served + 1) % 65536;
    chk("served_cnt", served_cnt_o, m_served);
    chk("end_busy", busy_o, 0);
    chk("tmo_count", n_tmo, m_tmo);
    chk("read_count", n_rd_acc - rd0, 1);
    chk("write_count", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      w = wr_q.pop_front();
      chk("write_addr", w.addr, CLAIM_ADDR);
      chk("write_data", w.data, id);
      chk("write_strb", w.strb, 'hF);
    end
    wr_q.delete();
  endtask

  initial begin
    logic [ID_W-1:0] rid;
    int rd0;
    arst_i       = 1'b1;
    en_i         = 1'b0;
    irq_i        = 1'b0;
    iob_ready_i  = 1'b0;
    iob_rvalid_i = 1'b0;
    iob_rdata_i  = '0;
    id_ready_i   = 1'b0;
    done_i       = 1'b0;
    tick();
    tick();
    chk("reset_bus", {iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
    chk("reset_out", {id_o, id_valid_o, spurious_o, served_cnt_o, busy_o, timeout_o}, 0);
    arst_i = 1'b0;
    tick();
    chk("post_reset_busy", busy_o, 0);

    // Basic claim at minimum latency, ID 5.
    run_claim(6'd5, 0, 0, 0, 0, 0, M_NORMAL);
    // Spurious claim.
    run_claim(6'd0, 0, 0, 0, 0, 0, M_NORMAL);
    // Backpressure on request and on handoff.
    run_claim(6'd42, 4, 1, 3, 2, 2, M_NORMAL);
    // Boundary IDs.
    run_claim(6'd63, 1, 0, 0, 0, 0, M_NORMAL);
    run_claim(6'd1, 0, 2, 1, 1, 1, M_NORMAL);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      rid = ($urandom_range(0, 4) == 0) ? '0 : ID_W'($urandom_range(1, 63));
      run_claim(rid, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 5), $urandom_range(0, 4), M_NORMAL);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    // Reset during SERVICE, then a fresh claim.
    run_claim(6'd7, 0, 0, 0, 0, 0, M_RESET);
    run_claim(6'd11, 0, 1, 0, 0, 0, M_NORMAL);

    // Handler never reports done.
    run_claim(6'd9, 0, 0, 0, 0, 0, M_NODONE);

    // Counter wrap: preload near the top instead of 65536 real completions.
    force dut.served_cnt_q = 16'hFFFE;
    #1;
    release dut.served_cnt_q;
    m_served = 'hFFFE;
    tick();
    chk("preload", served_cnt_o, 'hFFFE);
    run_claim(6'd3, 0, 0, 0, 0, 0, M_NORMAL);
    run_claim(6'd4, 0, 0, 0, 0, 0, M_NORMAL);
    chk("wrap_zero", served_cnt_o, 0);

    // Disabled: a pending irq must not start a claim.
    rd0   = n_rd_acc;
    en_i  = 1'b0;
    irq_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_blocked_busy", busy_o, 0);
    end
    chk("en_blocked_no_read", n_rd_acc - rd0, 0);
    irq_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
